// File: rtl/aes_block_sched.sv
// Block scheduler for an AES core: walks a job of 128-bit blocks through source fetch, engine, and sink store.
// Optional watchdog enabled by defining AES_SCHED_TIMEOUT_EN (limit set by TIMEOUT_CYC).
module aes_block_sched #(
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 16,
    parameter int BLOCK_BYTES = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  n_blocks_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    output logic              src_req_start_o,
    output logic              sink_req_start_o,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] sink_addr_o,
    input  logic              src_ready_start_i,
    input  logic              src_done_i,
    input  logic              sink_ready_start_i,
    input  logic              sink_done_i,
    output logic              eng_start_o,
    input  logic              eng_valid_i,
    output logic              done_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  blk_cnt_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ_SRC,
        COMPUTE,
        REQ_SINK,
        WAIT_SINK,
        FINISHED
    } state_t;

    state_t            r_state;
    state_t            w_state_base;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_src_addr;
    logic [ADDR_W-1:0] r_dst_addr;
    logic [CNT_W-1:0]  r_n_blocks;
    logic [CNT_W-1:0]  r_blk_cnt;
    logic [CNT_W-1:0]  w_blk_cnt_inc;
    logic              r_src_seen;
    logic              r_eng_start;
    logic              w_blk_done;
    logic              w_timeout;

    assign w_blk_cnt_inc = r_blk_cnt + CNT_W'(1);
    assign w_blk_done    = (r_state == WAIT_SINK) && sink_done_i;

    always_comb begin
        w_state_base = r_state;
        case (r_state)
            IDLE:      if (start_i) w_state_base = LOAD;
            LOAD:      w_state_base = (n_blocks_i == '0) ? FINISHED : REQ_SRC;
            REQ_SRC:   if (src_ready_start_i) w_state_base = COMPUTE;
            COMPUTE:   if (eng_valid_i) w_state_base = REQ_SINK;
            REQ_SINK:  if (sink_ready_start_i) w_state_base = WAIT_SINK;
            WAIT_SINK: begin
                if (sink_done_i) begin
                    w_state_base = (w_blk_cnt_inc == r_n_blocks) ? FINISHED : REQ_SRC;
                end
            end
            FINISHED:  w_state_base = IDLE;
            default:   w_state_base = IDLE;
        endcase
    end

    // A watchdog expiry overrides whatever the handshake logic wanted.
    assign w_state_next = w_timeout ? FINISHED : w_state_base;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_state     <= IDLE;
            r_src_addr  <= '0;
            r_dst_addr  <= '0;
            r_n_blocks  <= '0;
            r_blk_cnt   <= '0;
            r_src_seen  <= 1'b0;
            r_eng_start <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            // Engine start fires once per block, the cycle after the source stream completes,
            // even if the engine already reported valid in that same cycle.
            r_eng_start <= (r_state == COMPUTE) && src_done_i && !r_src_seen;
            if (r_state == REQ_SRC) begin
                r_src_seen <= 1'b0;
            end else if ((r_state == COMPUTE) && src_done_i) begin
                r_src_seen <= 1'b1;
            end
            if (r_state == LOAD) begin
                r_src_addr <= src_base_i;
                r_dst_addr <= dst_base_i;
                r_n_blocks <= n_blocks_i;
                r_blk_cnt  <= '0;
            end else if (w_blk_done) begin
                r_blk_cnt  <= w_blk_cnt_inc;
                r_src_addr <= r_src_addr + ADDR_W'(BLOCK_BYTES);
                r_dst_addr <= r_dst_addr + ADDR_W'(BLOCK_BYTES);
            end
        end
    end

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;
    logic            w_wd_active;

    assign w_wd_active = (r_state == REQ_SRC) || (r_state == COMPUTE) ||
                         (r_state == REQ_SINK) || (r_state == WAIT_SINK);
    assign w_timeout   = w_wd_active && (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            // Counts consecutive cycles in one waiting state; any transition restarts it.
            if (w_wd_active && (w_state_next == r_state)) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end else begin
                r_wd_cnt <= '0;
            end
            if (r_state == LOAD) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    assign src_req_start_o  = (r_state == REQ_SRC);
    assign sink_req_start_o = (r_state == REQ_SINK);
    assign done_o           = (r_state == FINISHED);
    assign busy_o           = (r_state != IDLE);
    assign eng_start_o      = r_eng_start;
    assign src_addr_o       = r_src_addr;
    assign sink_addr_o      = r_dst_addr;
    assign blk_cnt_o        = r_blk_cnt;

endmodule

// File: tb/tb_aes_block_sched.sv
// Directed bench for aes_block_sched with reactive streamer/engine models and an address/count scoreboard.
module tb_aes_block_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clear;
    logic        start_i;
    logic [15:0] n_blocks_i;
    logic [31:0] src_base_i;
    logic [31:0] dst_base_i;
    logic        src_req_start_o;
    logic        sink_req_start_o;
    logic [31:0] src_addr_o;
    logic [31:0] sink_addr_o;
    logic        src_ready_start_i;
    logic        src_done_i = 1'b0;
    logic        sink_ready_start_i;
    logic        sink_done_i = 1'b0;
    logic        eng_start_o;
    logic        eng_valid_i;
    logic        done_o;
    logic        busy_o;
    logic [15:0] blk_cnt_o;
    logic        err_o;

    logic src_rdy_en   = 1'b1;
    logic sink_rdy_en  = 1'b1;
    logic sink_done_en = 1'b1;
    logic eng_mode     = 1'b0;

    int total = 0;
    int bad   = 0;
    int src_acc = 0;
    int sink_acc = 0;
    int eng_cnt = 0;
    int done_cnt = 0;

    logic [31:0] q_src[$];
    logic [31:0] q_dst[$];
    logic [15:0] q_done[$];

    always #5 clk = ~clk;

    aes_block_sched #(
        .ADDR_W(32), .CNT_W(16), .BLOCK_BYTES(16), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start_i),
        .n_blocks_i(n_blocks_i), .src_base_i(src_base_i), .dst_base_i(dst_base_i),
        .src_req_start_o(src_req_start_o), .sink_req_start_o(sink_req_start_o),
        .src_addr_o(src_addr_o), .sink_addr_o(sink_addr_o),
        .src_ready_start_i(src_ready_start_i), .src_done_i(src_done_i),
        .sink_ready_start_i(sink_ready_start_i), .sink_done_i(sink_done_i),
        .eng_start_o(eng_start_o), .eng_valid_i(eng_valid_i),
        .done_o(done_o), .busy_o(busy_o), .blk_cnt_o(blk_cnt_o), .err_o(err_o)
    );

    // Streamers grant immediately and finish one cycle after the grant.
    assign src_ready_start_i  = src_req_start_o & src_rdy_en;
    assign sink_ready_start_i = sink_req_start_o & sink_rdy_en;
    assign eng_valid_i        = eng_mode ? src_done_i : eng_start_o;

    always @(posedge clk) begin
        src_done_i  <= src_req_start_o & src_ready_start_i;
        sink_done_i <= sink_req_start_o & sink_ready_start_i & sink_done_en;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] ea;
        logic [15:0] ec;
        if (src_req_start_o && src_ready_start_i) begin
            src_acc++;
            ea = (q_src.size() != 0) ? q_src.pop_front() : 'x;
            check("src_addr", src_addr_o, ea);
        end
        if (sink_req_start_o && sink_ready_start_i) begin
            sink_acc++;
            ea = (q_dst.size() != 0) ? q_dst.pop_front() : 'x;
            check("sink_addr", sink_addr_o, ea);
        end
        if (eng_start_o) eng_cnt++;
        if (done_o) begin
            done_cnt++;
            ec = (q_done.size() != 0) ? q_done.pop_front() : 'x;
            check("blk_cnt_at_done", blk_cnt_o, ec);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [15:0] n, input logic [31:0] s, input logic [31:0] d);
        logic [31:0] a;
        logic [31:0] b;
        a = s;
        b = d;
        for (int i = 0; i < int'(n); i++) begin
            q_src.push_back(a);
            q_dst.push_back(b);
            a = a + 32'd16;
            b = b + 32'd16;
        end
        q_done.push_back(n);
        n_blocks_i = n;
        src_base_i = s;
        dst_base_i = d;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        for (int i = 0; i < budget && done_cnt == d0; i++) tick();
        check("done_seen", done_cnt, d0 + 1);
    endtask

    task automatic wait_blk(input logic [15:0] v, input int budget);
        for (int i = 0; i < budget && blk_cnt_o != v; i++) tick();
        check("blk_reached", blk_cnt_o, v);
    endtask

    task automatic flush_sb();
        q_src.delete();
        q_dst.delete();
        q_done.delete();
    endtask

    initial begin
        int d0, a0, s0, e0, c;
        reset_n = 1'b0; clear = 1'b0; start_i = 1'b0;
        n_blocks_i = '0; src_base_i = '0; dst_base_i = '0;
        repeat (3) tick();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_src_req", src_req_start_o, 0);
        check("rst_sink_req", sink_req_start_o, 0);
        check("rst_eng", eng_start_o, 0);
        check("rst_src_addr", src_addr_o, 0);
        check("rst_sink_addr", sink_addr_o, 0);
        check("rst_blk", blk_cnt_o, 0);
        check("rst_err", err_o, 0);
        reset_n = 1'b1;
        tick();

        // Three blocks, immediate handshakes, plus minimum per-block latency.
        d0 = done_cnt; a0 = src_acc; e0 = eng_cnt;
        start_job(16'd3, 32'h1000, 32'h2000);
        for (int i = 0; i < 10 && !src_req_start_o; i++) tick();
        check("j1_src_req", src_req_start_o, 1);
        c = 0;
        while (blk_cnt_o != 16'd1 && c < 50) begin tick(); c++; end
        check("j1_latency", c, 5);
        wait_done(d0, 100);
        tick();
        check("j1_blk", blk_cnt_o, 3);
        check("j1_src_end", src_addr_o, 32'h1030);
        check("j1_sink_end", sink_addr_o, 32'h2030);
        check("j1_busy", busy_o, 0);
        check("j1_src_cnt", src_acc - a0, 3);
        check("j1_eng_cnt", eng_cnt - e0, 3);
        check("j1_sb_left", q_src.size() + q_dst.size() + q_done.size(), 0);

        // Empty job: done two cycles after start, no traffic.
        d0 = done_cnt; a0 = src_acc; s0 = sink_acc; e0 = eng_cnt;
        start_job(16'd0, 32'h5555_0000, 32'h6666_0000);
        check("n0_done_early", done_o, 0);
        tick();
        check("n0_done", done_o, 1);
        check("n0_blk", blk_cnt_o, 0);
        tick();
        check("n0_done_once", done_o, 0);
        check("n0_busy", busy_o, 0);
        check("n0_src", src_acc - a0, 0);
        check("n0_sink", sink_acc - s0, 0);
        check("n0_eng", eng_cnt - e0, 0);
        check("n0_done_cnt", done_cnt - d0, 1);

        // Address wrap at the top of the space.
        d0 = done_cnt;
        start_job(16'd2, 32'hFFFF_FFF0, 32'hFFFF_FFE0);
        wait_done(d0, 100);
        tick();
        check("wrap_src_end", src_addr_o, 32'h0000_0010);
        check("wrap_sink_end", sink_addr_o, 32'h0000_0000);
        check("wrap_blk", blk_cnt_o, 2);

        // Soft clear while the second block waits on the sink.
        d0 = done_cnt;
        start_job(16'd3, 32'h4000, 32'h5000);
        wait_blk(16'd1, 50);
        sink_done_en = 1'b0;
        s0 = sink_acc;
        for (int i = 0; i < 50 && sink_acc == s0; i++) tick();
        check("clr_sink_acc", sink_acc, s0 + 1);
        tick();
        tick();
        check("clr_pre_busy", busy_o, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_busy", busy_o, 0);
        check("clr_blk", blk_cnt_o, 0);
        check("clr_src_addr", src_addr_o, 0);
        check("clr_sink_addr", sink_addr_o, 0);
        flush_sb();
        sink_done_en = 1'b1;
        repeat (3) tick();
        check("clr_no_done", done_cnt, d0);
        d0 = done_cnt;
        start_job(16'd2, 32'h0100, 32'h0200);
        wait_done(d0, 100);
        tick();
        check("clr_rerun_blk", blk_cnt_o, 2);
        check("clr_rerun_src", src_addr_o, 32'h0120);

        // Source done and engine valid together, and a stray start mid-job.
        eng_mode = 1'b1;
        d0 = done_cnt; a0 = src_acc; e0 = eng_cnt;
        start_job(16'd3, 32'h3000, 32'h6000);
        wait_blk(16'd1, 50);
        n_blocks_i = 16'd5;
        src_base_i = 32'h9000;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(d0, 100);
        repeat (4) tick();
        check("same_blk", blk_cnt_o, 3);
        check("same_src_cnt", src_acc - a0, 3);
        check("same_eng_cnt", eng_cnt - e0, 3);
        check("same_done_cnt", done_cnt - d0, 1);
        check("same_busy", busy_o, 0);
        check("same_src_end", src_addr_o, 32'h3030);
        eng_mode = 1'b0;

        // Sink never grants: watchdog behaviour depends on the build.
        sink_rdy_en = 1'b0;
        d0 = done_cnt;
`ifdef AES_SCHED_TIMEOUT_EN
        q_done.push_back(16'd0);
`endif
        n_blocks_i = 16'd1; src_base_i = 32'h7000; dst_base_i = 32'h8000;
        q_src.push_back(32'h7000);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 20 && !sink_req_start_o; i++) tick();
        check("wd_in_req_sink", sink_req_start_o, 1);
        c = 0;
        while (!done_o && c < 40) begin tick(); c++; end
`ifdef AES_SCHED_TIMEOUT_EN
        check("wd_cycles", c, 8);
        check("wd_err", err_o, 1);
        check("wd_done", done_o, 1);
        tick();
        check("wd_err_sticky", err_o, 1);
        check("wd_idle", busy_o, 0);
`else
        check("nowd_no_done", done_cnt, d0);
        check("nowd_hold", sink_req_start_o, 1);
        check("nowd_err", err_o, 0);
`endif
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("wd_clr_err", err_o, 0);
        check("wd_clr_busy", busy_o, 0);
        flush_sb();
        sink_rdy_en = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
